pipeline_memory_writeback: RTL
==============================

# pipeline_memory_writeback

Memory/writeback stage of the 16-bit pipeline, directly downstream of the execute stage. It accepts each completed instruction from execute and does one of three things: issues the store to data memory, performs a load (with memory's one-cycle synchronous read), or writes the ALU result back to the register file. A two-state load sequencer backpressures execute while a load is in flight. The stage also keeps a retired-instruction counter.

## Interface
Parameters:
- LOAD_OPCODE, 4'hA, opcode value (instr[15:12]) for a load; address = execute_result
- STORE_OPCODE, 4'hB, opcode value for a store; address = execute_result, data = execute_store_data
- NOP_OPCODE, 4'hF, opcode value with no architectural effect (still retires)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high reset
- execute_done  in  1  execute presents a valid instruction this cycle
- execute_instr  in  16  instruction word; rd = instr[11:9]
- execute_result  in  16  ALU result or effective address
- execute_store_data  in  16  store data (rn value)
- stall_memory  out  1  high = execute must hold its outputs
- mem_write  out  1  data-memory write strobe
- mem_write_address  out  16  store address
- mem_write_input  out  16  store data
- mem_read_address  out  16  load address
- mem_read_output  in  16  read data, valid the cycle after the address is presented
- regfile_write  out  1  register-file write enable
- regfile_write_reg_num  out  3  destination register
- regfile_write_data  out  16  writeback value
- retired_count  out  16  instructions retired since reset

## Operation
- Handshake: the stage accepts an instruction on a clock edge where execute_done=1 and stall_memory=0. When execute_done=1 and stall_memory=1, nothing is sampled; execute must hold.
- State machine: IDLE, LOAD_ISSUE, LOAD_DATA. stall_memory = (state != IDLE), driven combinationally from the state register.
- IDLE, accept of an ALU op (not load, store or NOP): next cycle regfile_write=1, regfile_write_reg_num=rd, regfile_write_data=execute_result, for one cycle.
- IDLE, accept of a store: next cycle mem_write=1, mem_write_address=execute_result, mem_write_input=execute_store_data, for one cycle. No regfile write.
- IDLE, accept of a NOP: no side effects; retires only.
- IDLE, accept of a load: latch rd and the address, then go to LOAD_ISSUE.
- LOAD_ISSUE: drive mem_read_address with the latched address (held throughout the load); go to LOAD_DATA.
- LOAD_DATA: register mem_read_output into the writeback registers; go to IDLE. regfile_write=1 in the following cycle with the loaded data.
- In IDLE, mem_read_address holds its last value. It has no side effect.
- r0 is an ordinary writable register; no special-casing.
- retired_count increments by 1 in the cycle any retirement pulse is visible: an ALU writeback, a load writeback, a store's mem_write pulse, or the cycle after a NOP accept. It wraps 16'hFFFF -> 16'h0000.
- A load writeback and the accept of the next instruction can occur on the same edge (the state is IDLE again). The two outputs appear in consecutive cycles; there is never a double pulse.

## Timing
- Reset: the state goes to IDLE. stall_memory, mem_write, regfile_write = 0. All address, data, reg_num and retired_count outputs = 0.
- Reset mid-load, in LOAD_ISSUE or LOAD_DATA: the load is aborted, with no regfile write and no retirement count.
- Accept on edge N is the cycle-N setup; outputs are registered.
  - ALU or store: effect visible in cycle N+1 (1-cycle latency).
  - Load: address in cycle N+1, data sampled at the end of N+2, regfile_write in cycle N+3 (3-cycle latency).
- stall_memory is high in cycles N+1 and N+2 of a load. The earliest next accept is edge N+3.
- Back-to-back ALU or store instructions sustain 1 per cycle.
- All pulses (mem_write, regfile_write) are exactly one cycle wide unless a new accept occurs on the next edge.

## Test plan
- Reset: hold reset 2 cycles while execute_done=1 with an ALU op -> all outputs 0 and state IDLE; after release, the first accept produces regfile_write.
- ALU stream: instrs 16'h0200 and 16'h0400 (rd=1, rd=2) on consecutive cycles with results 16'h1234 and 16'h5678 -> regfile_write on 2 consecutive cycles: (1, 16'h1234) then (2, 16'h5678). retired_count = 2.
- Store: instr 16'hB000, result 16'h0040, store_data 16'hBEEF -> next cycle mem_write=1, address 16'h0040, input 16'hBEEF. No regfile_write.
- Load with stall: instr 16'hAE00 (rd=7), address 16'h0010, memory returns 16'hCAFE.
  - stall_memory high for exactly 2 cycles.
  - mem_read_address = 16'h0010.
  - regfile_write (7, 16'hCAFE) at N+3.
  - An ALU op held by execute during the stall is accepted at edge N+3, and its writeback lands at N+4.
- Reset mid-load: assert reset in LOAD_DATA -> no regfile_write follows, and retired_count = 0.
- Counter wrap: preload via 65535 NOPs (or force), then retire one more -> retired_count = 16'h0000.

Source files
------------

// File: rtl/pipeline_memory_writeback.sv
// Memory/writeback stage of the 16-bit pipeline.
// Takes completed instructions from execute and either issues a store to data
// memory, runs a load through the synchronous-read memory (stalling execute
// while the load is in flight), or writes the ALU result to the register file.
// Also keeps a wrapping count of retired instructions.
//
// Ports:
//   clk, reset              pipeline clock, synchronous active-high reset
//   execute_done            execute presents a valid instruction
//   execute_instr           instruction word (opcode [15:12], rd [11:9])
//   execute_result          ALU result or effective address
//   execute_store_data      store data
//   stall_memory            execute must hold its outputs
//   mem_write, mem_write_address, mem_write_input   store port
//   mem_read_address, mem_read_output               load port (1-cycle read)
//   regfile_write, regfile_write_reg_num, regfile_write_data   writeback port
//   retired_count           instructions retired since reset
module pipeline_memory_writeback #(
    parameter logic [3:0] LOAD_OPCODE  = 4'hA,
    parameter logic [3:0] STORE_OPCODE = 4'hB,
    parameter logic [3:0] NOP_OPCODE   = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        execute_done,
    input  logic [15:0] execute_instr,
    input  logic [15:0] execute_result,
    input  logic [15:0] execute_store_data,
    output logic        stall_memory,
    output logic        mem_write,
    output logic [15:0] mem_write_address,
    output logic [15:0] mem_write_input,
    output logic [15:0] mem_read_address,
    input  logic [15:0] mem_read_output,
    output logic        regfile_write,
    output logic [2:0]  regfile_write_reg_num,
    output logic [15:0] regfile_write_data,
    output logic [15:0] retired_count
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] LOAD_ISSUE = 2'd1;
    localparam logic [1:0] LOAD_DATA  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [REG_W-1:0] load_rd;
    logic [3:0]       opcode;
    logic [REG_W-1:0] rd;
    logic             accept;
    logic             is_load;
    logic             is_store;
    logic             is_nop;
    logic             unused_instr_bits;

    assign opcode   = execute_instr[15:12];
    assign rd       = execute_instr[11:9];
    assign is_load  = (opcode == LOAD_OPCODE);
    assign is_store = (opcode == STORE_OPCODE);
    assign is_nop   = (opcode == NOP_OPCODE);

    // Operand fields below rd belong to execute; this stage never looks at them.
    assign unused_instr_bits = ^execute_instr[8:0];

    // Execute may only hand over an instruction while no load is in flight.
    assign stall_memory = (state != IDLE);
    assign accept       = execute_done && (state == IDLE);

    // Load sequencer next-state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (accept && is_load) state_next = LOAD_ISSUE;
            LOAD_ISSUE: state_next = LOAD_DATA;
            LOAD_DATA:  state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered side effects: pulses default low, addresses/data hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_write             <= 1'b0;
            mem_write_address     <= '0;
            mem_write_input       <= '0;
            mem_read_address      <= '0;
            regfile_write         <= 1'b0;
            regfile_write_reg_num <= '0;
            regfile_write_data    <= '0;
            retired_count         <= '0;
            load_rd               <= '0;
        end else begin
            mem_write     <= 1'b0;
            regfile_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_load) begin
                            // Address is presented to memory during LOAD_ISSUE
                            // and held until the next load.
                            load_rd          <= rd;
                            mem_read_address <= execute_result;
                        end else if (is_store) begin
                            mem_write         <= 1'b1;
                            mem_write_address <= execute_result;
                            mem_write_input   <= execute_store_data;
                            retired_count     <= retired_count + DATA_W'(1);
                        end else if (is_nop) begin
                            retired_count <= retired_count + DATA_W'(1);
                        end else begin
                            regfile_write         <= 1'b1;
                            regfile_write_reg_num <= rd;
                            regfile_write_data    <= execute_result;
                            retired_count         <= retired_count + DATA_W'(1);
                        end
                    end
                end
                LOAD_DATA: begin
                    // Read data is valid now, one cycle after the address.
                    regfile_write         <= 1'b1;
                    regfile_write_reg_num <= load_rd;
                    regfile_write_data    <= mem_read_output;
                    retired_count         <= retired_count + DATA_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
